// File: rtl/fifo_interface_buffer.sv
// ----------------------------------------------------------------------------
// fifo_interface_buffer
//
// Single-clock synchronous FIFO used as elastic storage between two
// FIFOInterface-style streams (host_in, host_out, mem_read, mem_write paths).
// A word moves on a rising clk edge on any port where enable && ready.
//
// Ports
//   clk         single clock
//   reset       asynchronous, active-high reset
//   in_data     write-side data
//   in_enable   write-side valid
//   in_ready    write-side ready (FIFO not full)
//   out_data    head of queue, first-word fall-through
//   out_enable  read-side valid (FIFO not empty)
//   out_ready   read-side consumer ready
//   count       words currently stored, 0..depth
// ----------------------------------------------------------------------------
module fifo_interface_buffer #(
   parameter int num_bits  = 16,
   parameter int log_depth = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [num_bits-1:0]  in_data,
   input  logic                 in_enable,
   output logic                 in_ready,
   output logic [num_bits-1:0]  out_data,
   output logic                 out_enable,
   input  logic                 out_ready,
   output logic [log_depth:0]   count
);

   localparam int depth = 2 ** log_depth;
   localparam logic [log_depth:0] count_full = (log_depth + 1)'(depth);

   logic [num_bits-1:0]  mem [depth];
   logic [log_depth-1:0] wptr;
   logic [log_depth-1:0] rptr;
   logic                 push;
   logic                 pop;

   // Flags come straight from count, so clearing count on reset drops
   // out_enable asynchronously and leaves in_ready high.  in_ready stays low
   // for the whole cycle at full even if a pop happens, which keeps the
   // write side free of any combinational path from out_ready.
   assign in_ready   = (count != count_full);
   assign out_enable = (count != '0);

   assign push = in_enable && in_ready;
   assign pop  = out_enable && out_ready;

   // Head of queue is presented combinationally; forced to zero while empty
   // so unreset storage is never visible (also gives out_data = 0 in reset).
   assign out_data = out_enable ? mem[rptr] : '0;

   // Storage is deliberately not reset; only accepted words are written, so
   // in_data is ignored whenever in_enable is low.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_interface_buffer.sv
module tb_fifo_interface_buffer;

   localparam int NB    = 16;
   localparam int LD    = 4;
   localparam int DEPTH = 16;

   logic          clk;
   logic          reset;
   logic [NB-1:0] in_data;
   logic          in_enable;
   logic          in_ready;
   logic [NB-1:0] out_data;
   logic          out_enable;
   logic          out_ready;
   logic [LD:0]   count;

   int checks;
   int failures;

   logic [NB-1:0] sb_q[$];

   fifo_interface_buffer #(.num_bits(NB), .log_depth(LD)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_enable  (in_enable),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_enable (out_enable),
      .out_ready  (out_ready),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle, entered just after a rising edge. Outputs are checked
   // at the falling edge against the scoreboard; the scoreboard is updated
   // from the bench's own view of push/pop acceptance.
   task automatic cycle(input logic en, input logic [NB-1:0] d, input logic rdy, input string tag);
      int  n;
      bit  p_push;
      bit  p_pop;
      in_enable = en;
      in_data   = d;
      out_ready = rdy;
      n = sb_q.size();
      p_push = en && (n != DEPTH);
      p_pop  = rdy && (n != 0);
      @(negedge clk);
      chk({tag, ".count"},      32'(count),      32'(n));
      chk({tag, ".in_ready"},   32'(in_ready),   32'(n != DEPTH));
      chk({tag, ".out_enable"}, 32'(out_enable), 32'(n != 0));
      if (n != 0) chk({tag, ".out_data"}, 32'(out_data), 32'(sb_q[0]));
      @(posedge clk);
      #1;
      if (p_pop)  void'(sb_q.pop_front());
      if (p_push) sb_q.push_back(d);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      in_enable = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // 1. reset held for 100 ns
      #50;
      chk("rst_during.count",      32'(count),      32'd0);
      chk("rst_during.out_enable", 32'(out_enable), 32'd0);
      chk("rst_during.in_ready",   32'(in_ready),   32'd1);
      chk("rst_during.out_data",   32'(out_data),   32'd0);
      #50;
      reset = 1'b0;
      @(posedge clk);
      #1;
      cycle(1'b0, 16'h0000, 1'b0, "rst_after");

      // 2. four words, stalled consumer, then drain
      for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(i), 1'b0, "push4");
      for (int i = 0; i < 5; i++) cycle(1'b0, 16'hxxxx, 1'b1, "drain4");
      chk("drain4.empty_count", 32'(count), 32'd0);

      // simultaneous push and pop at empty: only the push happens
      cycle(1'b1, 16'h0A0A, 1'b1, "empty_pp");
      cycle(1'b0, 16'h0000, 1'b1, "empty_pp_out");

      // 3. fill to full with in_enable held high; 17th word is dropped
      for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 16'h1000 + 16'(i), 1'b0, "fill");
      chk("full.in_ready", 32'(in_ready), 32'd0);
      // at full, push attempt plus pop: pop only, in_ready back next cycle
      cycle(1'b1, 16'hDEAD, 1'b1, "full_pp");
      cycle(1'b0, 16'h0000, 1'b0, "full_recover");
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 16'h0000, 1'b1, "drain16");
      chk("drain16.empty", 32'(out_enable), 32'd0);

      // 4. steady state at count = 3 across several pointer wraps
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'h2000 + 16'(i), 1'b0, "prime3");
      for (int i = 3; i < 103; i++) cycle(1'b1, 16'h2000 + 16'(i), 1'b1, "stream");
      chk("stream.count", 32'(count), 32'd3);
      for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, "stream_drain");

      // 5. first-word latency into an empty FIFO
      in_enable = 1'b1;
      in_data   = 16'hBEEF;
      out_ready = 1'b0;
      @(negedge clk);
      chk("beef.push_cycle_out_enable", 32'(out_enable), 32'd0);
      @(posedge clk);
      #1;
      in_enable = 1'b0;
      @(negedge clk);
      chk("beef.next_out_enable", 32'(out_enable), 32'd1);
      chk("beef.next_out_data",   32'(out_data),   32'h0000BEEF);
      @(posedge clk);
      #1;
      sb_q.push_back(16'hBEEF);
      cycle(1'b0, 16'h0000, 1'b1, "beef_pop");

      // 6. asynchronous reset with five words stored
      for (int i = 0; i < 5; i++) cycle(1'b1, 16'h3000 + 16'(i), 1'b0, "pre_rst");
      in_enable = 1'b0;
      chk("pre_rst.count", 32'(count), 32'd5);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst.out_enable", 32'(out_enable), 32'd0);
      chk("async_rst.count",      32'(count),      32'd0);
      chk("async_rst.in_ready",   32'(in_ready),   32'd1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      sb_q.delete();
      @(posedge clk);
      #1;
      cycle(1'b0, 16'h0000, 1'b1, "post_rst");
      cycle(1'b1, 16'h0077, 1'b0, "post_rst_push");
      cycle(1'b0, 16'h0000, 1'b1, "post_rst_pop");
      chk("post_rst.final_count", 32'(count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
